// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the tv80 bus bridge and bus monitors.
//   bridge_state_e : bridge FSM states
//   access_e       : classification of the current CPU strobe combination
//   STB_*          : bit positions of the active-low strobes in the packed strobe vector
package z80_bus_pkg;

  localparam int unsigned STB_W    = 6;
  localparam int unsigned STB_M1   = 0;
  localparam int unsigned STB_MREQ = 1;
  localparam int unsigned STB_IORQ = 2;
  localparam int unsigned STB_RD   = 3;
  localparam int unsigned STB_WR   = 4;
  localparam int unsigned STB_RFSH = 5;

  localparam int unsigned WCNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WS   = 2'd2,
    HOLD = 2'd3
  } bridge_state_e;

  typedef enum logic [2:0] {
    ACC_NONE = 3'd0,
    MEM_RD   = 3'd1,
    MEM_WR   = 3'd2,
    IO_RD    = 3'd3,
    IO_WR    = 3'd4,
    INTA     = 3'd5
  } access_e;

  // True for accesses that need a memory-port transaction.
  function automatic logic acc_is_xfer(input access_e k);
    return (k == MEM_RD) || (k == MEM_WR) || (k == IO_RD) || (k == IO_WR);
  endfunction

  function automatic logic acc_is_io(input access_e k);
    return (k == IO_RD) || (k == IO_WR);
  endfunction

  function automatic logic acc_is_wr(input access_e k);
    return (k == MEM_WR) || (k == IO_WR);
  endfunction

endpackage

// File: rtl/z80_strobe_decode.sv
// Combinational classifier of tv80 bus strobes into an access kind.
// Ports:
//   stb_n_i : packed active-low strobes {rfsh,wr,rd,iorq,mreq,m1} (positions from the package)
//   kind_o  : access kind; refresh never produces a memory access
module z80_strobe_decode
  import z80_bus_pkg::*;
(
  input  logic [STB_W-1:0] stb_n_i,
  output access_e          kind_o
);

  logic m1, mreq, iorq, rd, wr, rfsh;

  always_comb begin
    m1     = !stb_n_i[STB_M1];
    mreq   = !stb_n_i[STB_MREQ];
    iorq   = !stb_n_i[STB_IORQ];
    rd     = !stb_n_i[STB_RD];
    wr     = !stb_n_i[STB_WR];
    rfsh   = !stb_n_i[STB_RFSH];
    kind_o = ACC_NONE;
    // INTA wins: m1 together with iorq is an acknowledge, not a port access.
    if (m1 && iorq) begin
      kind_o = INTA;
    end else if (mreq && !rfsh && (rd || wr)) begin
      kind_o = wr ? MEM_WR : MEM_RD;
    end else if (iorq && (rd || wr)) begin
      kind_o = wr ? IO_WR : IO_RD;
    end
  end

endmodule

// File: rtl/z80_mem_bridge.sv
// Bridge from the tv80 CPU bus to a single-beat req/ack memory port.
// Each CPU access issues exactly one transaction; the CPU is stretched with
// cpu_wait_n until the data returns (plus WAIT_STATES extra cycles). I/O is
// mapped into memory space at {IO_PAGE, A[7:0]}; INTA returns INTA_VECTOR.
// Ports:
//   clk, reset_n            : clock, async active-low reset
//   cpu_a/cpu_do/cpu_di     : CPU address, write data, registered read data
//   cpu_*_n strobes         : m1, mreq, iorq, rd, wr, rfsh
//   cpu_wait_n              : combinational wait request (low = stretch)
//   mem_req/we/addr/wdata   : registered transaction request, held until mem_ack
//   mem_ack/mem_rdata       : completion pulse and read data
//   protocol_err            : sticky flag, strobes dropped while a request was pending
module z80_mem_bridge
  import z80_bus_pkg::*;
#(
  parameter logic [7:0]  IO_PAGE     = 8'h10,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [7:0]  INTA_VECTOR = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  output logic [7:0]  cpu_di,
  input  logic        cpu_m1_n,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_rfsh_n,
  output logic        cpu_wait_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        protocol_err
);

  // Counter preload so that WS lasts exactly WAIT_STATES cycles.
  localparam logic [WCNT_W-1:0] WS_LOAD =
    (WAIT_STATES == 0) ? '0 : WCNT_W'(WAIT_STATES - 1);

  bridge_state_e     state_q, state_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [15:0]       mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        cpu_di_q, cpu_di_d;
  logic              perr_q, perr_d;
  logic              abort_q, abort_d;

  logic [STB_W-1:0]  stb_n;
  access_e           kind;
  logic              access;

  // Pack strobes for the shared classifier.
  always_comb begin
    stb_n           = '1;
    stb_n[STB_M1]   = cpu_m1_n;
    stb_n[STB_MREQ] = cpu_mreq_n;
    stb_n[STB_IORQ] = cpu_iorq_n;
    stb_n[STB_RD]   = cpu_rd_n;
    stb_n[STB_WR]   = cpu_wr_n;
    stb_n[STB_RFSH] = cpu_rfsh_n;
  end

  z80_strobe_decode u_decode (
    .stb_n_i (stb_n),
    .kind_o  (kind)
  );

  assign access = acc_is_xfer(kind);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_di_q    <= 8'hFF;
      perr_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_di_q    <= cpu_di_d;
      perr_q      <= perr_d;
      abort_q     <= abort_d;
    end
  end

  // Next-state, latches and wait request.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_di_d    = cpu_di_q;
    perr_d      = perr_q;
    abort_d     = abort_q;
    cpu_wait_n  = 1'b1;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (kind == INTA) begin
          cpu_di_d = INTA_VECTOR;
        end else if (access) begin
          // Wait goes low in this very cycle so the CPU sees it on its first T-state.
          cpu_wait_n  = 1'b0;
          state_d     = REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = acc_is_wr(kind);
          mem_addr_d  = acc_is_io(kind) ? {IO_PAGE, cpu_a[7:0]} : cpu_a;
          mem_wdata_d = cpu_do;
        end
      end
      REQ: begin
        cpu_wait_n = 1'b0;
        if (!access) begin
          abort_d = 1'b0 | 1'b1;
          perr_d  = 1'b1;
        end
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            cpu_di_d = mem_rdata;
          end
          // An abandoned CPU cycle returns straight to IDLE once the port is free.
          if (!access || abort_q) begin
            state_d = IDLE;
          end else if (WAIT_STATES != 0) begin
            state_d = WS;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = HOLD;
          end
        end
      end
      WS: begin
        cpu_wait_n = 1'b0;
        if (cnt_q == '0) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        // Strobes must release before another access is recognised.
        if (!access) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!reset_n) begin
      cpu_wait_n = 1'b1;
    end
  end

  assign cpu_di       = cpu_di_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign protocol_err = perr_q;

endmodule
